mem_arbiter: RTL and testbench

//  Two-master wishbone arbiter sharing one memory-side port between the I-cache path and the
//  D-cache path (D side is the eviction write buffer's memory master). Sits between the L1

---
 rtl/mem_arbiter_pkg.sv | 39 +++
 rtl/mem_arbiter_control.sv | 70 +++++++
 rtl/mem_arbiter.sv | 98 +++++++++
 tb/tb_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-master memory arbiter: bus widths, FSM states and
// the round-robin winner selection.
package mem_arbiter_pkg;

  localparam int unsigned AdrWidth  = 16;
  localparam int unsigned DataWidth = 128;
  localparam int unsigned SelWidth  = DataWidth / 8;

  typedef logic [AdrWidth-1:0]  lc3b_word;
  typedef logic [DataWidth-1:0] lc3b_line;
  typedef logic [SelWidth-1:0]  lc3b_sel;

  typedef enum logic [1:0] {
    ArbIdle   = 2'd0,
    ArbGrantI = 2'd1,
    ArbGrantD = 2'd2
  } arb_state_t;

  typedef enum logic {
    SideI = 1'b0,
    SideD = 1'b1
  } arb_side_t;

  // On contention the side that did not win last time goes next.
  function automatic arb_side_t pick_winner(input logic      req_icache,
                                            input logic      req_dcache,
                                            input arb_side_t last_grant);
    arb_side_t winner;
    if (req_icache && req_dcache) begin
      winner = (last_grant == SideI) ? SideD : SideI;
    end else if (req_dcache) begin
      winner = SideD;
    end else begin
      winner = SideI;
    end
    return winner;
  endfunction

endpackage

// File: rtl/mem_arbiter_control.sv
// Arbitration FSM: tracks which master owns the memory port for one whole
// transaction and remembers the last winner for round-robin.
module mem_arbiter_control
  import mem_arbiter_pkg::*;
#(
  parameter logic FIRST_PRIO = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic icache_req_i,
  input  logic dcache_req_i,
  input  logic icache_cyc_i,
  input  logic dcache_cyc_i,
  input  logic mem_ack_i,
  output logic grant_icache_o,
  output logic grant_dcache_o
);

  arb_state_t state_q, state_d;
  arb_side_t  last_grant_q, last_grant_d;
  logic       grant_icache_q, grant_icache_d;
  logic       grant_dcache_q, grant_dcache_d;
  arb_side_t  winner;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    winner       = pick_winner(icache_req_i, dcache_req_i, last_grant_q);
    unique case (state_q)
      ArbIdle: begin
        if (icache_req_i || dcache_req_i) begin
          last_grant_d = winner;
          state_d      = (winner == SideD) ? ArbGrantD : ArbGrantI;
        end
      end
      // A completing ACK wins over a simultaneous CYC drop; both end the grant.
      ArbGrantI: begin
        if (mem_ack_i || !icache_cyc_i) begin
          state_d = ArbIdle;
        end
      end
      ArbGrantD: begin
        if (mem_ack_i || !dcache_cyc_i) begin
          state_d = ArbIdle;
        end
      end
      default: state_d = ArbIdle;
    endcase
    grant_icache_d = (state_d == ArbGrantI);
    grant_dcache_d = (state_d == ArbGrantD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ArbIdle;
      last_grant_q   <= arb_side_t'(~FIRST_PRIO);
      grant_icache_q <= 1'b0;
      grant_dcache_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      grant_icache_q <= grant_icache_d;
      grant_dcache_q <= grant_dcache_d;
    end
  end

  assign grant_icache_o = grant_icache_q;
  assign grant_dcache_o = grant_dcache_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-master wishbone arbiter: muxes the granted L1 master onto the shared
// memory port and gates ACK/RTY back to the requesters.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic FIRST_PRIO = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  // I-cache side
  input  logic     wb_icache_cyc_i,
  input  logic     wb_icache_stb_i,
  input  logic     wb_icache_we_i,
  input  lc3b_word wb_icache_adr_i,
  input  lc3b_line wb_icache_dat_m_i,
  input  lc3b_sel  wb_icache_sel_i,
  output lc3b_line wb_icache_dat_s_o,
  output logic     wb_icache_ack_o,
  output logic     wb_icache_rty_o,
  // D-cache / write-buffer side
  input  logic     wb_dcache_cyc_i,
  input  logic     wb_dcache_stb_i,
  input  logic     wb_dcache_we_i,
  input  lc3b_word wb_dcache_adr_i,
  input  lc3b_line wb_dcache_dat_m_i,
  input  lc3b_sel  wb_dcache_sel_i,
  output lc3b_line wb_dcache_dat_s_o,
  output logic     wb_dcache_ack_o,
  output logic     wb_dcache_rty_o,
  // Shared memory port
  output logic     wb_mem_cyc_o,
  output logic     wb_mem_stb_o,
  output logic     wb_mem_we_o,
  output lc3b_word wb_mem_adr_o,
  output lc3b_line wb_mem_dat_m_o,
  output lc3b_sel  wb_mem_sel_o,
  input  lc3b_line wb_mem_dat_s_i,
  input  logic     wb_mem_ack_i,
  input  logic     wb_mem_rty_i
);

  logic req_icache, req_dcache;
  logic grant_icache, grant_dcache;

  assign req_icache = wb_icache_cyc_i & wb_icache_stb_i;
  assign req_dcache = wb_dcache_cyc_i & wb_dcache_stb_i;

  mem_arbiter_control #(
    .FIRST_PRIO (FIRST_PRIO)
  ) u_control (
    .clk            (clk),
    .rst            (rst),
    .icache_req_i   (req_icache),
    .dcache_req_i   (req_dcache),
    .icache_cyc_i   (wb_icache_cyc_i),
    .dcache_cyc_i   (wb_dcache_cyc_i),
    .mem_ack_i      (wb_mem_ack_i),
    .grant_icache_o (grant_icache),
    .grant_dcache_o (grant_dcache)
  );

  // Memory port follows the granted master combinationally, so an abort
  // (CYC dropped) reaches memory in the same cycle.
  always_comb begin
    wb_mem_cyc_o   = 1'b0;
    wb_mem_stb_o   = 1'b0;
    wb_mem_we_o    = 1'b0;
    wb_mem_adr_o   = '0;
    wb_mem_dat_m_o = '0;
    wb_mem_sel_o   = '0;
    if (grant_dcache) begin
      wb_mem_cyc_o   = wb_dcache_cyc_i;
      wb_mem_stb_o   = wb_dcache_stb_i;
      wb_mem_we_o    = wb_dcache_we_i;
      wb_mem_adr_o   = wb_dcache_adr_i;
      wb_mem_dat_m_o = wb_dcache_dat_m_i;
      wb_mem_sel_o   = wb_dcache_sel_i;
    end else if (grant_icache) begin
      wb_mem_cyc_o   = wb_icache_cyc_i;
      wb_mem_stb_o   = wb_icache_stb_i;
      wb_mem_we_o    = wb_icache_we_i;
      wb_mem_adr_o   = wb_icache_adr_i;
      wb_mem_dat_m_o = wb_icache_dat_m_i;
      wb_mem_sel_o   = wb_icache_sel_i;
    end
  end

  assign wb_icache_ack_o = grant_icache & wb_mem_ack_i;
  assign wb_dcache_ack_o = grant_dcache & wb_mem_ack_i;

  // Owner sees memory's RTY; everyone else is told to retry while requesting.
  assign wb_icache_rty_o = grant_icache ? wb_mem_rty_i : req_icache;
  assign wb_dcache_rty_o = grant_dcache ? wb_mem_rty_i : req_dcache;

  assign wb_icache_dat_s_o = wb_mem_dat_s_i;
  assign wb_dcache_dat_s_o = wb_mem_dat_s_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected grants are queued as requests are
// raised and matched against what appears on the memory port.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  typedef struct packed {
    logic     is_d;
    logic     we;
    lc3b_word adr;
    lc3b_sel  sel;
    lc3b_line dat;
  } exp_t;

  logic     clk = 1'b0;
  logic     rst;
  logic     ic_cyc, ic_stb, ic_we, dc_cyc, dc_stb, dc_we;
  lc3b_word ic_adr, dc_adr;
  lc3b_line ic_dat, dc_dat;
  lc3b_sel  ic_sel, dc_sel;
  lc3b_line ic_dat_s, dc_dat_s;
  logic     ic_ack, ic_rty, dc_ack, dc_rty;
  logic     mem_cyc, mem_stb, mem_we;
  lc3b_word mem_adr;
  lc3b_line mem_dat_m, mem_dat_s;
  lc3b_sel  mem_sel;
  logic     mem_ack, mem_rty;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   n;
  exp_t e;

  always #5 clk = ~clk;

  mem_arbiter #(
    .FIRST_PRIO (1'b1)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .wb_icache_cyc_i   (ic_cyc),
    .wb_icache_stb_i   (ic_stb),
    .wb_icache_we_i    (ic_we),
    .wb_icache_adr_i   (ic_adr),
    .wb_icache_dat_m_i (ic_dat),
    .wb_icache_sel_i   (ic_sel),
    .wb_icache_dat_s_o (ic_dat_s),
    .wb_icache_ack_o   (ic_ack),
    .wb_icache_rty_o   (ic_rty),
    .wb_dcache_cyc_i   (dc_cyc),
    .wb_dcache_stb_i   (dc_stb),
    .wb_dcache_we_i    (dc_we),
    .wb_dcache_adr_i   (dc_adr),
    .wb_dcache_dat_m_i (dc_dat),
    .wb_dcache_sel_i   (dc_sel),
    .wb_dcache_dat_s_o (dc_dat_s),
    .wb_dcache_ack_o   (dc_ack),
    .wb_dcache_rty_o   (dc_rty),
    .wb_mem_cyc_o      (mem_cyc),
    .wb_mem_stb_o      (mem_stb),
    .wb_mem_we_o       (mem_we),
    .wb_mem_adr_o      (mem_adr),
    .wb_mem_dat_m_o    (mem_dat_m),
    .wb_mem_sel_o      (mem_sel),
    .wb_mem_dat_s_i    (mem_dat_s),
    .wb_mem_ack_i      (mem_ack),
    .wb_mem_rty_i      (mem_rty)
  );

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input lc3b_line obs, input lc3b_line exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic is_d, input logic we, input lc3b_word adr,
                              input lc3b_sel sel, input lc3b_line dat);
    exp_t r;
    r.is_d = is_d;
    r.we   = we;
    r.adr  = adr;
    r.sel  = sel;
    r.dat  = dat;
    return r;
  endfunction

  task automatic drive(input exp_t r);
    if (r.is_d) begin
      dc_adr = r.adr; dc_we = r.we; dc_sel = r.sel; dc_dat = r.dat;
      dc_cyc = 1'b1;  dc_stb = 1'b1;
    end else begin
      ic_adr = r.adr; ic_we = r.we; ic_sel = r.sel; ic_dat = r.dat;
      ic_cyc = 1'b1;  ic_stb = 1'b1;
    end
  endtask

  // Waits (bounded) for STB on the memory port and checks it against the queue head.
  task automatic wait_grant(output int waited, output exp_t got);
    waited = 0;
    got    = '0;
    @(negedge clk);
    while (!mem_stb && waited < 12) begin
      @(negedge clk);
      waited++;
    end
    check_bit("grant_seen", mem_stb, 1'b1);
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL sb_underflow: observed grant with no queued expectation");
      return;
    end
    got = sb.pop_front();
    check_vec("mem_adr", 128'(mem_adr), 128'(got.adr));
    check_bit("mem_we", mem_we, got.we);
    check_vec("mem_sel", 128'(mem_sel), 128'(got.sel));
    check_vec("mem_dat_m", mem_dat_m, got.dat);
  endtask

  // Memory ACKs after 'delay' wait cycles; checks forwarding and the IDLE gap.
  task automatic complete(input exp_t r, input int delay, input lc3b_line rdata,
                          input logic keep);
    for (int i = 0; i < delay; i++) begin
      tick();
      @(negedge clk);
      check_bit("hold_stb", mem_stb, 1'b1);
      check_bit("no_early_ack", r.is_d ? dc_ack : ic_ack, 1'b0);
    end
    tick();
    mem_ack   = 1'b1;
    mem_dat_s = rdata;
    @(negedge clk);
    check_bit("ack_fwd", r.is_d ? dc_ack : ic_ack, 1'b1);
    check_bit("ack_other", r.is_d ? ic_ack : dc_ack, 1'b0);
    check_vec("dat_s", r.is_d ? dc_dat_s : ic_dat_s, rdata);
    tick();
    mem_ack = 1'b0;
    if (!keep) begin
      if (r.is_d) begin dc_cyc = 1'b0; dc_stb = 1'b0; end
      else begin ic_cyc = 1'b0; ic_stb = 1'b0; end
    end
    @(negedge clk);
    check_bit("idle_gap", mem_cyc, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t d1, i1, i2, d3, i3, d4, i4, i5, d6, i6;
    rst = 1'b1;
    ic_cyc = 0; ic_stb = 0; ic_we = 0; ic_adr = '0; ic_dat = '0; ic_sel = '0;
    dc_cyc = 0; dc_stb = 0; dc_we = 0; dc_adr = '0; dc_dat = '0; dc_sel = '0;
    mem_ack = 0; mem_rty = 0; mem_dat_s = '0;

    // Reset state with requesters idle
    tick();
    tick();
    @(negedge clk);
    check_bit("rst_mem_cyc", mem_cyc, 1'b0);
    check_bit("rst_mem_stb", mem_stb, 1'b0);
    check_bit("rst_mem_we", mem_we, 1'b0);
    check_bit("rst_ic_ack", ic_ack, 1'b0);
    check_bit("rst_dc_ack", dc_ack, 1'b0);
    check_bit("rst_ic_rty", ic_rty, 1'b0);
    check_bit("rst_dc_rty", dc_rty, 1'b0);

    // 1: both requesting out of reset, D favoured first
    d1 = mk(1'b1, 1'b0, 16'h2222, 16'hffff, 128'hd1d1);
    i1 = mk(1'b0, 1'b0, 16'h1111, 16'h00ff, 128'h0);
    tick();
    drive(d1);
    drive(i1);
    tick();
    rst = 1'b0;
    sb.push_back(d1);
    sb.push_back(i1);
    wait_grant(n, e);
    check_vec("t1_latency", 128'(n), 128'(1));
    check_bit("t1_ic_rty", ic_rty, 1'b1);
    complete(e, 1, 128'hcafe_0001, 1'b0);
    wait_grant(n, e);
    check_vec("t1_second_latency", 128'(n), 128'(0));
    complete(e, 0, 128'hcafe_0002, 1'b0);

    // 2: I-only read, ACK five cycles into the grant
    i2 = mk(1'b0, 1'b0, 16'h1230, 16'hffff, 128'h0);
    tick();
    drive(i2);
    sb.push_back(i2);
    wait_grant(n, e);
    check_vec("t2_latency", 128'(n), 128'(1));
    check_bit("t2_dc_ack", dc_ack, 1'b0);
    complete(e, 4, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 1'b0);

    // 3: continuous contention alternates D,I,...
    d3 = mk(1'b1, 1'b1, 16'h3d00, 16'h0f0f, 128'h3d3d_3d3d);
    i3 = mk(1'b0, 1'b0, 16'h3100, 16'hf0f0, 128'h0);
    tick();
    drive(d3);
    drive(i3);
    for (int k = 0; k < 8; k++) sb.push_back((k % 2 == 0) ? d3 : i3);
    for (int k = 0; k < 8; k++) begin
      wait_grant(n, e);
      check_vec("t3_latency", 128'(n), 128'((k == 0) ? 1 : 0));
      check_bit("t3_order", e.is_d, (k % 2 == 0));
      complete(e, k % 3, 128'(32'h3000_0000 + k), (k < 6));
    end

    // 4: D write aborts two cycles into its grant; pending I follows
    d4 = mk(1'b1, 1'b1, 16'h4400, 16'h00f0, 128'h4444_5555);
    i4 = mk(1'b0, 1'b0, 16'h0440, 16'hffff, 128'h0);
    tick();
    drive(d4);
    drive(i4);
    sb.push_back(d4);
    sb.push_back(i4);
    wait_grant(n, e);
    check_bit("t4_first_is_d", e.is_d, 1'b1);
    tick();
    tick();
    dc_cyc = 1'b0;
    dc_stb = 1'b0;
    @(negedge clk);
    check_bit("t4_abort_cyc", mem_cyc, 1'b0);
    check_bit("t4_abort_stb", mem_stb, 1'b0);
    check_bit("t4_abort_ack", dc_ack, 1'b0);
    check_bit("t4_ic_rty", ic_rty, 1'b1);
    wait_grant(n, e);
    check_vec("t4_i_latency", 128'(n), 128'(1));
    complete(e, 0, 128'h4040, 1'b0);

    // 5: reset while I waits on ACK; late ACK must be dropped
    i5 = mk(1'b0, 1'b0, 16'h5550, 16'hffff, 128'h0);
    tick();
    drive(i5);
    sb.push_back(i5);
    wait_grant(n, e);
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    check_bit("t5_cyc_during_rst", mem_cyc, 1'b1);
    tick();
    rst     = 1'b0;
    mem_ack = 1'b1;
    ic_cyc  = 1'b0;
    ic_stb  = 1'b0;
    @(negedge clk);
    check_bit("t5_mem_cyc", mem_cyc, 1'b0);
    check_bit("t5_ic_ack", ic_ack, 1'b0);
    check_bit("t5_dc_ack", dc_ack, 1'b0);
    tick();
    mem_ack = 1'b0;

    // 6: memory RTY during D grant; grant held, later ACK to D only
    d6 = mk(1'b1, 1'b0, 16'h6660, 16'h3c3c, 128'h6);
    i6 = mk(1'b0, 1'b0, 16'h0660, 16'hffff, 128'h0);
    drive(d6);
    drive(i6);
    sb.push_back(d6);
    sb.push_back(i6);
    wait_grant(n, e);
    check_bit("t6_first_is_d", e.is_d, 1'b1);
    tick();
    mem_rty = 1'b1;
    @(negedge clk);
    check_bit("t6_dc_rty", dc_rty, 1'b1);
    check_bit("t6_ic_rty", ic_rty, 1'b1);
    check_bit("t6_dc_ack", dc_ack, 1'b0);
    tick();
    @(negedge clk);
    check_bit("t6_held_stb", mem_stb, 1'b1);
    check_vec("t6_held_adr", 128'(mem_adr), 128'(16'h6660));
    tick();
    mem_rty = 1'b0;
    @(negedge clk);
    check_bit("t6_dc_rty_clear", dc_rty, 1'b0);
    complete(e, 0, 128'h6666_7777, 1'b0);
    wait_grant(n, e);
    check_bit("t6_then_i", e.is_d, 1'b0);
    complete(e, 0, 128'h0606, 1'b0);

    check_vec("sb_drained", 128'(sb.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
